i2sm_tdm_tx: RTL and testbench
==============================

# i2sm_tdm_tx

Parametrised multi-channel audio serial transmitter. It generates bit clock, frame/word clock and serial data from the audio master clock, and supports I2S, left-justified and TDM (DSP mode A) framing with configurable channel count and slot width. It sits at the codec edge of the playback path, pulling one frame of samples per frame period from an upstream FWFT FIFO. It uses flat ports and needs no interface wrapper.

## Interface
- DW, 24: sample width in bits, transmitted MSB first.
- SW, 32: slot width in sclk periods. Requires SW >= DW; unused LSBs are padded with zeros.
- NCH, 2: channels per frame, 2..16. Must be even when FMT is 0 or 1.
- SCLK_DIV, 4: clk cycles per sclk period. Must be even and >= 2.
- FMT, 0: 0 = I2S, 1 = left-justified, 2 = TDM/DSP-A.
- Derived: N = NCH*SW bits per frame, H = N/2, frame length = N*SCLK_DIV clk cycles (256 at defaults).
- Elaboration fails on any illegal parameter combination.
- clk  in  1  audio master clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rd_en  out  1  one-cycle read strobe, one pulse per frame.
- i_valid  in  1  upstream has data; sampled only when rd_en=1.
- i_data  in  NCH*DW  frame samples; channel k occupies bits [k*DW +: DW].
- sclk  out  1  bit clock.
- lrclk  out  1  word clock (I2S, LJ) or frame sync (TDM).
- sdo  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame was loaded without valid data.

## Operation
- Counters:
  - phase runs 0..SCLK_DIV-1 and wraps.
  - b (bit index) runs 0..N-1 and advances when phase wraps.
- Stream bit s(i), for i in 0..N-1: slot k = i/SW, j = i%SW. s(i) = channel k bit (DW-1-j) when j < DW, else 0.
- Frame buffer: NCH*DW register, cleared on reset, loaded on the clk edge ending the cycle (b=N-1, phase=SCLK_DIV-1).
  - If i_valid=1 on that edge: load i_data.
  - If i_valid=0: load all zeros and pulse underrun for one cycle. The pulse coincides with the first cycle of the next frame.
- rd_en is high exactly during the cycle (b=N-1, phase=SCLK_DIV-1). i_valid is ignored in all other cycles.
- Per-bit outputs, held for the whole bit period:
  - I2S: lrclk = 0 for b < H, else 1. sdo(b) = s(b-1); at b=0 it is the previous frame's s(N-1), which is 0 after reset. For NCH > 2, slots 0..NCH/2-1 fall in the low half.
  - LJ: lrclk = 1 for b < H, else 0. sdo(b) = s(b).
  - TDM: lrclk = 1 only at b = N-1 (one sclk before slot-0 MSB). sdo(b) = s(b).
- sclk = 0 for phase < SCLK_DIV/2, 1 otherwise. Data and lrclk change only at sclk falling edges; the receiver samples on rising edges.
- SW == DW is legal; there is no padding in that case.

## Timing
- All outputs are registered.
- Reset values: sclk=0, sdo=0, rd_en=0, underrun=0, lrclk = 0 (I2S), 1 (LJ), 0 (TDM). Counters are at b=0, phase=0.
- After rst deasserts, the first frame transmits zeros.
- The first rd_en occurs in clk cycle N*SCLK_DIV-1 counted from the first non-reset cycle (cycle 0). rd_en then repeats every N*SCLK_DIV cycles.
- Latency from the rd_en cycle:
  - LJ/TDM: the channel-0 MSB appears on sdo in the next clk cycle (b=0, phase=0).
  - I2S: the channel-0 MSB appears one sclk period later (b=1).
- rst asserted mid-frame: all outputs and counters return to reset values on the next edge. The in-flight frame is abandoned and no rd_en or underrun is issued.
- rst asserted in the rd_en cycle: rst wins. There is no load and no underrun.

## Test plan
- Defaults (I2S, 24/32, NCH=2), ch0=0xABCDEF, ch1=0x123456, i_valid=1:
  - lrclk is low for 32 sclk.
  - sdo bits b=1..24 are 0xABCDEF MSB first; b=25..32 are 0.
  - b=33..56 are 0x123456.
- Frame timing after reset: first rd_en at cycle 255, then every 256 cycles.
  - sclk period is 4 clk, with 2 clk low followed by 2 clk high.
  - sdo is stable across every sclk rising edge.
- i_valid=0 at one rd_en: that frame's sdo is all zeros and underrun pulses exactly once. The next valid frame is transmitted normally.
- FMT=1 with the same data: lrclk is high for b=0..31 and 0xABCDEF starts at b=0.
- FMT=2, NCH=8, SW=32, SCLK_DIV=2, ch k = 0x100000+k:
  - lrclk is high only at b=255.
  - ch k MSB is at b=32k.
  - rd_en occurs every 512 clk.
- rst asserted at b=10: the next-edge outputs match the reset values. After release, the next rd_en arrives 256 cycles later (cycle 255) and no underrun pulses.

Source files
------------

// File: rtl/i2sm_tdm_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2sm_tdm_tx
//  Description : Multi-channel audio serial transmitter. Derives sclk, lrclk
//                and sdo from the master clock and supports I2S,
//                left-justified and TDM (DSP mode A) framing. It pulls one
//                frame of samples per frame period from an upstream FWFT FIFO.
//  Ports       : clk      - master clock
//                rst      - synchronous active-high reset
//                rd_en    - one-cycle FIFO read strobe, once per frame
//                i_valid  - FIFO has data, sampled only while rd_en=1
//                i_data   - frame samples, channel k at [k*DW +: DW]
//                sclk     - bit clock
//                lrclk    - word clock (I2S/LJ) or frame sync (TDM)
//                sdo      - serial data, MSB first
//                underrun - one-cycle pulse when a frame was loaded empty
//  Revision    : 1.0 - initial release
// ============================================================================
module i2sm_tdm_tx #(
    parameter int DW       = 24,
    parameter int SW       = 32,
    parameter int NCH      = 2,
    parameter int SCLK_DIV = 4,
    parameter int FMT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    input  logic              i_valid,
    input  logic [NCH*DW-1:0] i_data,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdo,
    output logic              underrun
);

    localparam int c_nbits = NCH * SW;
    localparam int c_bw    = $clog2(c_nbits);
    localparam int c_pw    = $clog2(SCLK_DIV);

    localparam logic [c_bw-1:0] c_last_bit = c_bw'(c_nbits - 1);
    localparam logic [c_bw-1:0] c_half_bit = c_bw'(c_nbits / 2);
    localparam logic [c_pw-1:0] c_last_ph  = c_pw'(SCLK_DIV - 1);
    localparam logic [c_pw-1:0] c_sclk_hi  = c_pw'(SCLK_DIV / 2);

    generate
        if (DW < 1 || SW < DW || NCH < 2 || NCH > 16 ||
            (FMT != 2 && (NCH % 2) != 0) ||
            SCLK_DIV < 2 || (SCLK_DIV % 2) != 0 ||
            FMT < 0 || FMT > 2) begin : g_param_error
            $error("i2sm_tdm_tx: illegal parameter combination");
        end
    endgenerate

    logic [c_pw-1:0]     r_phase;
    logic [c_bw-1:0]     r_bit;
    logic [NCH*DW-1:0]   r_buf;

    logic                w_load;
    logic [NCH*DW-1:0]   w_buf_next;
    logic [c_pw-1:0]     w_phase_nx;
    logic [c_bw-1:0]     w_bit_nx;
    logic [c_nbits-1:0]  w_stream;
    logic                w_prev_last;
    logic                w_sdo_nx;
    logic                w_lrclk_nx;

    // Last cycle of the frame: this edge latches the next frame's samples.
    assign w_load     = (r_bit == c_last_bit) && (r_phase == c_last_ph);
    assign w_buf_next = w_load ? (i_valid ? i_data : '0) : r_buf;

    always_comb begin
        w_phase_nx = r_phase + 1'b1;
        w_bit_nx   = r_bit;
        if (r_phase == c_last_ph) begin
            w_phase_nx = '0;
            w_bit_nx   = (r_bit == c_last_bit) ? '0 : r_bit + 1'b1;
        end
    end

    // Frame laid out in transmit order: stream bit i is slot i/SW, position
    // i%SW; positions past the sample width are zero padding.
    generate
        for (genvar gi = 0; gi < c_nbits; gi++) begin : g_stream
            localparam int c_slot = gi / SW;
            localparam int c_pos  = gi % SW;
            if (c_pos < DW) begin : g_data
                assign w_stream[gi] = w_buf_next[c_slot*DW + DW-1-c_pos];
            end else begin : g_pad
                assign w_stream[gi] = 1'b0;
            end
        end

        // I2S delays data by one bit, so bit 0 of a frame carries the final
        // stream bit of the frame that just ended (still in r_buf here).
        if (SW == DW) begin : g_prev_data
            assign w_prev_last = r_buf[(NCH-1)*DW];
        end else begin : g_prev_pad
            assign w_prev_last = 1'b0;
        end
    endgenerate

    always_comb begin
        w_sdo_nx   = 1'b0;
        w_lrclk_nx = 1'b0;
        if (FMT == 0) begin
            w_lrclk_nx = (w_bit_nx >= c_half_bit);
            w_sdo_nx   = (w_bit_nx == '0) ? w_prev_last
                                          : w_stream[w_bit_nx - 1'b1];
        end else if (FMT == 1) begin
            w_lrclk_nx = (w_bit_nx < c_half_bit);
            w_sdo_nx   = w_stream[w_bit_nx];
        end else begin
            w_lrclk_nx = (w_bit_nx == c_last_bit);
            w_sdo_nx   = w_stream[w_bit_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= '0;
            r_bit    <= '0;
            r_buf    <= '0;
            sclk     <= 1'b0;
            sdo      <= 1'b0;
            rd_en    <= 1'b0;
            underrun <= 1'b0;
            lrclk    <= (FMT == 1);
        end else begin
            r_phase  <= w_phase_nx;
            r_bit    <= w_bit_nx;
            r_buf    <= w_buf_next;
            sclk     <= (w_phase_nx >= c_sclk_hi);
            rd_en    <= (w_bit_nx == c_last_bit) && (w_phase_nx == c_last_ph);
            underrun <= w_load && !i_valid;
            lrclk    <= w_lrclk_nx;
            // sdo only moves at bit boundaries (sclk falling edge); in
            // between it must hold even after r_buf has been reloaded.
            if (w_phase_nx == '0) begin
                sdo <= w_sdo_nx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2sm_tdm_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2sm_tdm_tx
//  Description : Self-checking bench for i2sm_tdm_tx. Three instances (I2S
//                defaults, left-justified, 8-channel TDM) share clk/rst. A
//                frame-level model predicts every output on every cycle, and
//                directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2sm_tdm_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         v_i = 1'b0, v_l = 1'b0, v_t = 1'b0;
    logic [47:0]  d_i = '0, d_l = '0;
    logic [191:0] d_t = '0;

    logic rd_i, sclk_i, lr_i, sdo_i, ur_i_dut;
    logic rd_l, sclk_l, lr_l, sdo_l, ur_l_dut;
    logic rd_t, sclk_t, lr_t, sdo_t, ur_t_dut;

    i2sm_tdm_tx u_i2s (
        .clk(clk), .rst(rst), .rd_en(rd_i), .i_valid(v_i), .i_data(d_i),
        .sclk(sclk_i), .lrclk(lr_i), .sdo(sdo_i), .underrun(ur_i_dut)
    );

    i2sm_tdm_tx #(.FMT(1)) u_lj (
        .clk(clk), .rst(rst), .rd_en(rd_l), .i_valid(v_l), .i_data(d_l),
        .sclk(sclk_l), .lrclk(lr_l), .sdo(sdo_l), .underrun(ur_l_dut)
    );

    i2sm_tdm_tx #(.NCH(8), .SCLK_DIV(2), .FMT(2)) u_tdm (
        .clk(clk), .rst(rst), .rd_en(rd_t), .i_valid(v_t), .i_data(d_t),
        .sclk(sclk_t), .lrclk(lr_t), .sdo(sdo_t), .underrun(ur_t_dut)
    );

    int nchk = 0;
    int nerr = 0;

    // ------------------------------------------------------------------
    // Frame-level model: cycle index since reset plus the frames in flight.
    // ------------------------------------------------------------------
    int           mt = 0;
    logic         started = 1'b0;
    logic [47:0]  cur_i = '0, prev_i = '0, cur_l = '0;
    logic [191:0] cur_t = '0;
    logic         m_ur_i = 1'b0, m_ur_l = 1'b0, m_ur_t = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mt      <= 0;
            started <= 1'b1;
            cur_i   <= '0;
            prev_i  <= '0;
            cur_l   <= '0;
            cur_t   <= '0;
            m_ur_i  <= 1'b0;
            m_ur_l  <= 1'b0;
            m_ur_t  <= 1'b0;
        end else if (started) begin
            mt     <= mt + 1;
            m_ur_i <= (mt % 256 == 255) && !v_i;
            m_ur_l <= (mt % 256 == 255) && !v_l;
            m_ur_t <= (mt % 512 == 511) && !v_t;
            if (mt % 256 == 255) begin
                prev_i <= cur_i;
                cur_i  <= v_i ? d_i : '0;
                cur_l  <= v_l ? d_l : '0;
            end
            if (mt % 512 == 511) cur_t <= v_t ? d_t : '0;
        end
    end

    // Stream bit i of a frame: slot i/sw, position i%sw, MSB first, zero pad.
    function automatic logic s_bit(input logic [191:0] d, input int i,
                                   input int dw, input int sw);
        int k, j;
        k = i / sw;
        j = i % sw;
        if (j < dw) return d[k*dw + dw-1-j];
        return 1'b0;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0d act=%b exp=%b", nm, mt, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0d act=%h exp=%h", nm, mt, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare and recording, on the falling edge.
    // ------------------------------------------------------------------
    logic rec_en = 1'b0;
    logic rs_i [0:1023], rl_i [0:1023], rs_l [0:1023], rl_l [0:1023];
    logic rs_t [0:1023], rl_t [0:1023];
    int   rdt_i [0:3], rdt_l [0:3], rdt_t [0:3];
    int   rdn_i = 0, rdn_l = 0, rdn_t = 0;
    int   ur_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                int ph, b;
                ph = mt % 4;
                b  = (mt / 4) % 64;
                chk1("i2s_sclk", sclk_i, ph >= 2);
                chk1("i2s_rd_en", rd_i, mt % 256 == 255);
                chk1("i2s_lrclk", lr_i, b >= 32);
                chk1("i2s_sdo", sdo_i, (b == 0) ? s_bit({144'b0, prev_i}, 63, 24, 32)
                                                : s_bit({144'b0, cur_i}, b - 1, 24, 32));
                chk1("i2s_underrun", ur_i_dut, m_ur_i);
                chk1("lj_sclk", sclk_l, ph >= 2);
                chk1("lj_rd_en", rd_l, mt % 256 == 255);
                chk1("lj_lrclk", lr_l, b < 32);
                chk1("lj_sdo", sdo_l, s_bit({144'b0, cur_l}, b, 24, 32));
                chk1("lj_underrun", ur_l_dut, m_ur_l);
                ph = mt % 2;
                b  = (mt / 2) % 256;
                chk1("tdm_sclk", sclk_t, ph == 1);
                chk1("tdm_rd_en", rd_t, mt % 512 == 511);
                chk1("tdm_lrclk", lr_t, b == 255);
                chk1("tdm_sdo", sdo_t, s_bit(cur_t, b, 24, 32));
                chk1("tdm_underrun", ur_t_dut, m_ur_t);

                if (ur_i_dut === 1'b1) ur_cnt++;
                if (rec_en) begin
                    if (mt / 4 < 1024) begin
                        rs_i[mt/4] = sdo_i; rl_i[mt/4] = lr_i;
                        rs_l[mt/4] = sdo_l; rl_l[mt/4] = lr_l;
                    end
                    if (mt / 2 < 1024) begin
                        rs_t[mt/2] = sdo_t; rl_t[mt/2] = lr_t;
                    end
                    if (rd_i === 1'b1 && rdn_i < 4) begin rdt_i[rdn_i] = mt; rdn_i++; end
                    if (rd_l === 1'b1 && rdn_l < 4) begin rdt_l[rdn_l] = mt; rdn_l++; end
                    if (rd_t === 1'b1 && rdn_t < 4) begin rdt_t[rdn_t] = mt; rdn_t++; end
                end
            end
        end
    end

    task automatic wait_mt(input int n);
        int guard;
        guard = 0;
        while (mt != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (mt != n) begin
            nchk++;
            nerr++;
            $display("FAIL wait_mt act=%0d exp=%0d", mt, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus and literal expectations.
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] w64;
        logic [23:0] w24;
        logic [7:0]  w8;
        int          ones, ur_base;

        repeat (3) @(negedge clk);
        chk1("rst_i2s_sclk", sclk_i, 1'b0);
        chk1("rst_i2s_sdo", sdo_i, 1'b0);
        chk1("rst_i2s_rd_en", rd_i, 1'b0);
        chk1("rst_i2s_underrun", ur_i_dut, 1'b0);
        chk1("rst_i2s_lrclk", lr_i, 1'b0);
        chk1("rst_lj_lrclk", lr_l, 1'b1);
        chk1("rst_tdm_lrclk", lr_t, 1'b0);

        rst    = 1'b0;
        rec_en = 1'b1;
        v_i = 1'b1; d_i = {24'h123456, 24'hABCDEF};
        v_l = 1'b1; d_l = {24'h123456, 24'hABCDEF};
        v_t = 1'b1;
        for (int k = 0; k < 8; k++) d_t[k*24 +: 24] = 24'h100000 + 24'(k);

        wait_mt(400);
        v_i = 1'b0;                               // frame 2 will underrun
        wait_mt(600);
        v_i = 1'b1; d_i = {24'h13579B, 24'h2468AC};
        wait_mt(1300);
        rec_en = 1'b0;

        // I2S frame 1 occupies bit periods 64..127
        for (int x = 0; x < 64; x++) w64[x] = rl_i[64 + x];
        chk("i2s_lrclk_frame", w64, 64'hFFFFFFFF_00000000);
        for (int x = 0; x < 24; x++) w24 = {w24[22:0], rs_i[65 + x]};
        chk("i2s_ch0", 64'(w24), 64'hABCDEF);
        for (int x = 0; x < 8; x++) w8 = {w8[6:0], rs_i[89 + x]};
        chk("i2s_pad", 64'(w8), 64'h0);
        for (int x = 0; x < 24; x++) w24 = {w24[22:0], rs_i[97 + x]};
        chk("i2s_ch1", 64'(w24), 64'h123456);
        for (int x = 0; x < 64; x++) w64[x] = rs_i[128 + x];
        chk("i2s_underrun_frame", w64, 64'h0);
        for (int x = 0; x < 24; x++) w24 = {w24[22:0], rs_i[193 + x]};
        chk("i2s_after_underrun", 64'(w24), 64'h2468AC);
        chk("i2s_underrun_count", 64'(ur_cnt), 64'd1);
        chk("i2s_rd0", 64'(rdt_i[0]), 64'd255);
        chk("i2s_rd1", 64'(rdt_i[1]), 64'd511);

        for (int x = 0; x < 64; x++) w64[x] = rl_l[64 + x];
        chk("lj_lrclk_frame", w64, 64'h00000000_FFFFFFFF);
        for (int x = 0; x < 24; x++) w24 = {w24[22:0], rs_l[64 + x]};
        chk("lj_ch0", 64'(w24), 64'hABCDEF);
        chk("lj_rd0", 64'(rdt_l[0]), 64'd255);

        // TDM frame 1 occupies bit periods 256..511
        for (int k = 0; k < 8; k++) begin
            for (int x = 0; x < 24; x++) w24 = {w24[22:0], rs_t[256 + 32*k + x]};
            chk("tdm_slot", 64'(w24), 64'h100000 + 64'(k));
        end
        ones = 0;
        for (int x = 256; x < 512; x++) if (rl_t[x] === 1'b1) ones++;
        chk("tdm_sync_count", 64'(ones), 64'd1);
        chk1("tdm_sync_pos", rl_t[511], 1'b1);
        chk("tdm_rd0", 64'(rdt_t[0]), 64'd511);
        chk("tdm_rd1", 64'(rdt_t[1]), 64'd1023);

        // Reset in the middle of an I2S frame (bit 10)
        wait_mt(1321);
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_sclk", sclk_i, 1'b0);
        chk1("mid_rst_sdo", sdo_i, 1'b0);
        chk1("mid_rst_lrclk", lr_i, 1'b0);
        chk1("mid_rst_rd_en", rd_i, 1'b0);
        chk1("mid_rst_lj_lrclk", lr_l, 1'b1);
        rst = 1'b0;
        ur_base = ur_cnt;
        v_i = 1'b0; v_l = 1'b0; v_t = 1'b0;

        wait_mt(254);
        chk1("post_rst_rd_early", rd_i, 1'b0);
        wait_mt(255);
        chk1("post_rst_rd", rd_i, 1'b1);
        rst = 1'b1;                               // reset lands on the load edge
        @(negedge clk);
        chk1("rst_on_load_underrun", ur_i_dut, 1'b0);
        chk1("rst_on_load_lj_underrun", ur_l_dut, 1'b0);
        rst = 1'b0;
        wait_mt(200);
        chk("post_rst_underrun_count", 64'(ur_cnt - ur_base), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
